// File: rtl/stream_demux_2way.sv
// stream_demux_2way: steer one val/rdy stream into two outputs, each behind its own 2-entry FIFO
module stream_demux_2way #(
  parameter int nbits = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_sel,
  input  logic [nbits-1:0] in_msg,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [nbits-1:0] out0_msg,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [nbits-1:0] out1_msg
);
  logic [1:0] rdy_v, val_v, full_v, enq_v, deq_v;
  logic [nbits-1:0] msg_v [2];
  assign rdy_v = {out1_rdy, out0_rdy};
  // in_rdy looks only at stored occupancy so out*_rdy never reaches it combinationally
  assign in_rdy = !full_v[in_sel];
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [1:0] cnt;
    logic hp, tp;
    logic [nbits-1:0] mem [2];
    assign val_v[i] = cnt != 2'd0;
    assign full_v[i] = cnt == 2'd2;
    assign enq_v[i] = in_val && in_rdy && (in_sel == 1'(i));
    assign deq_v[i] = val_v[i] && rdy_v[i];
    assign msg_v[i] = mem[hp];
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= 2'd0;
        hp <= 1'b0;
        tp <= 1'b0;
        mem[0] <= '0;
        mem[1] <= '0;
      end else begin
        if (enq_v[i]) begin
          mem[tp] <= in_msg;
          tp <= ~tp;
        end
        if (deq_v[i]) hp <= ~hp;
        cnt <= cnt + {1'b0, enq_v[i]} - {1'b0, deq_v[i]};
      end
    end
  end
  assign out0_val = val_v[0];
  assign out1_val = val_v[1];
  assign out0_msg = msg_v[0];
  assign out1_msg = msg_v[1];
endmodule
